// File: rtl/csdf_pkg.sv
// csdf_pkg: shared constants and helpers for the CSDF accumulator/demux pair.
// Both sides derive the tag and payload widths from here, so the tag
// packing of the tagged stream always matches on producer and consumer.
package csdf_pkg;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Tag field width for a given number of fluxes.
  function automatic int tag_width(input int flux);
    return clog2(flux);
  endfunction

  // Payload width left over once the tag occupies the MSBs.
  function automatic int payload_width(input int width, input int flux);
    return width - clog2(flux);
  endfunction

endpackage

// File: rtl/csdf_tag_fifo.sv
// csdf_tag_fifo: DATA_W x DEPTH synchronous FIFO with show-ahead head data.
// Ports:
//   ck, rst        clock, synchronous active-high reset (control state only)
//   wr, wr_data    push request and payload (ignored while full or in reset)
//   rd             pop request (ignored while empty)
//   full, empty    status decoded from the registered occupancy count
//   head           entry at the read pointer, read combinationally
module csdf_tag_fifo
  import csdf_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A pop on an empty FIFO is dropped, so a write+read while empty is a
  // plain write; pointers wrap naturally since DEPTH is a power of two.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; writes in a reset cycle are discarded.
  always_ff @(posedge ck) begin
    if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/csdf_tag_demux.sv
// csdf_tag_demux: splits the tagged accumulator stream into per-flux FIFOs.
// Ports:
//   ck, rst     clock, synchronous active-high reset
//   in0_wr      write strobe for the tagged token
//   in0_data    token; tag in [WIDTH-1:DATA_W], payload in [DATA_W-1:0]
//   in0_full    backpressure, high while any flux FIFO is full
//   out_data    show-ahead head payload per flux, flux f at [f*DATA_W +: DATA_W]
//   out_empty   per-flux empty flags
//   out_read    per-flux pop strobes
//   tag_err     sticky flag, set when a token is dropped
module csdf_tag_demux
  import csdf_pkg::*;
#(
  parameter int FLUX  = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int TAG_WIDTH = tag_width(FLUX),
  localparam int DATA_W    = payload_width(WIDTH, FLUX)
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   in0_wr,
  input  logic [WIDTH-1:0]       in0_data,
  output logic                   in0_full,
  output logic [DATA_W*FLUX-1:0] out_data,
  output logic [FLUX-1:0]        out_empty,
  input  logic [FLUX-1:0]        out_read,
  output logic                   tag_err
);

  logic [TAG_WIDTH-1:0] tag;
  logic [DATA_W-1:0]    payload;
  logic                 tag_ok;
  logic                 accept;
  logic [FLUX-1:0]      full_vec;

  assign tag     = in0_data[WIDTH-1:DATA_W];
  assign payload = in0_data[DATA_W-1:0];
  // Out-of-range tags only exist when FLUX is not a power of two.
  assign tag_ok  = (32'(tag) < 32'(FLUX));
  // Any full flux stalls the whole stream, keeping in0_full a pure
  // function of registered counts with no path from in0_data.
  assign in0_full = |full_vec;
  assign accept   = in0_wr & ~in0_full & tag_ok;

  for (genvar f = 0; f < FLUX; f++) begin : g_flux
    csdf_tag_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .ck      (ck),
      .rst     (rst),
      .wr      (accept && (tag == TAG_WIDTH'(f))),
      .wr_data (payload),
      .rd      (out_read[f]),
      .full    (full_vec[f]),
      .empty   (out_empty[f]),
      .head    (out_data[f*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      tag_err <= 1'b0;
    end else if (in0_wr && (in0_full || !tag_ok)) begin
      tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csdf_tag_demux.sv
module tb_csdf_tag_demux;

  logic        ck;
  logic        rst;

  // FLUX=2, WIDTH=8, DEPTH=4 instance
  logic        in0_wr;
  logic [7:0]  in0_data;
  logic        in0_full;
  logic [13:0] out_data;
  logic [1:0]  out_empty;
  logic [1:0]  out_read;
  logic        tag_err;

  // FLUX=3, WIDTH=8, DEPTH=4 instance
  logic        in3_wr;
  logic [7:0]  in3_data;
  logic        in3_full;
  logic [17:0] out3_data;
  logic [2:0]  out3_empty;
  logic [2:0]  out3_read;
  logic        tag_err3;

  int checks;
  int errors;
  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic exp_err;

  csdf_tag_demux #(.FLUX(2), .WIDTH(8), .DEPTH(4)) dut (
    .ck(ck), .rst(rst), .in0_wr(in0_wr), .in0_data(in0_data),
    .in0_full(in0_full), .out_data(out_data), .out_empty(out_empty),
    .out_read(out_read), .tag_err(tag_err)
  );

  csdf_tag_demux #(.FLUX(3), .WIDTH(8), .DEPTH(4)) dut3 (
    .ck(ck), .rst(rst), .in0_wr(in3_wr), .in0_data(in3_data),
    .in0_full(in3_full), .out_data(out3_data), .out_empty(out3_empty),
    .out_read(out3_read), .tag_err(tag_err3)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_empty", 32'(out_empty), 32'({q1.size() == 0, q0.size() == 0}));
    chk("in0_full", 32'(in0_full), 32'(q0.size() == 4 || q1.size() == 4));
    chk("tag_err", 32'(tag_err), 32'(exp_err));
  endtask

  // One clock on the FLUX=2 instance with scoreboard prediction.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic [1:0] rd);
    logic full_m;
    full_m = (q0.size() == 4) || (q1.size() == 4);
    if (rd[0] && q0.size() > 0) chk("pop0", 32'(out_data[6:0]), 32'(q0.pop_front()));
    if (rd[1] && q1.size() > 0) chk("pop1", 32'(out_data[13:7]), 32'(q1.pop_front()));
    if (wr) begin
      if (full_m) exp_err = 1'b1;
      else if (d[7]) q1.push_back(d[6:0]);
      else q0.push_back(d[6:0]);
    end
    in0_wr = wr;
    in0_data = d;
    out_read = rd;
    @(posedge ck); #1;
    in0_wr = 1'b0;
    out_read = 2'b00;
    check_state();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_err = 1'b0;
    in0_wr = 1'b0; in0_data = '0; out_read = '0;
    in3_wr = 1'b0; in3_data = '0; out3_read = '0;

    // Reset
    rst = 1'b1;
    @(posedge ck); #1;
    rst = 1'b0;
    check_state();
    chk("rst_empty3", 32'(out3_empty), 32'h7);
    chk("rst_err3", 32'(tag_err3), 32'h0);

    // Routing
    cycle(1'b1, 8'h85, 2'b00);
    chk("route1", 32'(out_data[13:7]), 32'h05);
    cycle(1'b1, 8'h03, 2'b00);
    chk("route0", 32'(out_data[6:0]), 32'h03);
    cycle(1'b0, 8'h00, 2'b11);

    // Backpressure and pointer wrap on flux 0
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 2'b00);
    chk("full_after4", 32'(in0_full), 32'h1);
    cycle(1'b1, 8'h05, 2'b00);
    chk("drop_err", 32'(tag_err), 32'h1);
    cycle(1'b0, 8'h00, 2'b01);
    chk("full_fall", 32'(in0_full), 32'h0);
    cycle(1'b1, 8'h06, 2'b00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'b01);
    chk("drained0", 32'(out_empty[0]), 32'h1);

    // Simultaneous read and write on flux 1 at count 2
    cycle(1'b1, 8'h81, 2'b00);
    cycle(1'b1, 8'h82, 2'b00);
    cycle(1'b1, 8'h90, 2'b10);
    chk("rw_full", 32'(in0_full), 32'h0);
    cycle(1'b0, 8'h00, 2'b10);
    chk("rw_not_empty", 32'(out_empty[1]), 32'h0);
    cycle(1'b0, 8'h00, 2'b10);
    chk("rw_empty", 32'(out_empty[1]), 32'h1);

    // Read while empty is ignored
    cycle(1'b0, 8'h00, 2'b11);

    // Bad tag on the FLUX=3 instance
    in3_wr = 1'b1; in3_data = 8'h85;
    @(posedge ck); #1;
    in3_wr = 1'b0;
    chk("f3_empty_ok", 32'(out3_empty), 32'h3);
    chk("f3_data", 32'(out3_data[17:12]), 32'h05);
    chk("f3_err_ok", 32'(tag_err3), 32'h0);
    in3_wr = 1'b1; in3_data = 8'hC7;
    @(posedge ck); #1;
    in3_wr = 1'b0;
    chk("f3_bad_err", 32'(tag_err3), 32'h1);
    chk("f3_bad_empty", 32'(out3_empty), 32'h3);

    // Reset mid-stream with a concurrent write
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h10 + 8'(i), 2'b00);
    chk("pre_rst_empty", 32'(out_empty), 32'h2);
    rst = 1'b1; in0_wr = 1'b1; in0_data = 8'h07; out_read = 2'b01;
    @(posedge ck); #1;
    rst = 1'b0; in0_wr = 1'b0; out_read = 2'b00;
    q0.delete(); q1.delete(); exp_err = 1'b0;
    check_state();
    chk("rst_f3_err", 32'(tag_err3), 32'h0);
    cycle(1'b0, 8'h00, 2'b00);
    cycle(1'b1, 8'h2A, 2'b00);
    chk("post_rst_data", 32'(out_data[6:0]), 32'h2A);
    cycle(1'b0, 8'h00, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csdf_tag_demux.md
# csdf_tag_demux

Downstream consumer of the CSDF multi-flux accumulator. Accepts the single tagged output stream (tag in the MSBs, payload in the LSBs) through a FIFO-style write/full handshake. Strips the tag and steers each payload into a per-flux FIFO. Each FIFO is exposed as an independent empty/read/data port, so every flux can be consumed by its own downstream actor.

## Interface
- FLUX, 2, number of fluxes; must be ≥2.
- WIDTH, 8, width of the tagged input word.
- DEPTH, 4, entries per flux FIFO; must be a power of two and ≥2.
- TAG_WIDTH, $clog2(FLUX), derived; tag field width.
- DATA_W, WIDTH-TAG_WIDTH, derived; payload width.
- ck  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous and active-high.
- in0_wr  in  1  write strobe from the accumulator.
- in0_data  in  WIDTH  tagged token; tag = [WIDTH-1:DATA_W], payload = [DATA_W-1:0].
- in0_full  out  1  backpressure; high when any flux FIFO is full.
- out_data  out  DATA_W*FLUX  head payload per flux; flux f occupies [f*DATA_W +: DATA_W].
- out_empty  out  FLUX  bit f high when FIFO f is empty.
- out_read  in  FLUX  bit f pops FIFO f.
- tag_err  out  1  sticky; set by any dropped token.

## Operation
- Per-flux FIFO f state is defined by count_f (width $clog2(DEPTH+1)):
  - EMPTY when count_f = 0.
  - PARTIAL when 0 < count_f < DEPTH.
  - FULL when count_f = DEPTH.
- Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- Accepted write: in0_wr=1, in0_full=0 and tag<FLUX. The payload goes to FIFO[tag] at the write pointer; that pointer increments and count_f increments.
- Accepted read: out_read[f]=1 and out_empty[f]=0. The read pointer increments and count_f decrements.
- Simultaneous accepted write and read on the same flux: both occur and count_f is unchanged. This holds in PARTIAL state. In EMPTY state the write happens and the read is ignored.
- in0_full is the OR of all FULL flags. It is conservative: a full flux blocks all fluxes. This keeps the output free of any combinational path from in0_data.
- Dropped token: a write with in0_full=1, or a tag ≥ FLUX (only possible when FLUX is not a power of two). Nothing is stored, no pointer moves, and tag_err is set.
- Read while empty: ignored, with no error.
- out_data is show-ahead: it shows the head entry of each FIFO combinationally from storage. The value is undefined but stable while that FIFO is empty.
- Reset values:
  - All counts and pointers are 0.
  - out_empty is all ones.
  - in0_full is 0 and tag_err is 0.
  - Storage is not reset.
- Reset mid-operation flushes every FIFO on the next edge. Any in0_wr or out_read in that cycle is ignored.

## Timing
- Write-to-output latency is 1 cycle. A token accepted at edge k clears out_empty[tag] and appears on out_data after edge k. There is no same-cycle bypass.
- A pop at edge k presents the next entry after edge k.
- in0_full follows registered counts:
  - It rises in the cycle after the write that fills a FIFO.
  - It falls in the cycle after a pop from a FULL FIFO.
- Sustained throughput is one write per cycle plus one read per flux per cycle.
- All outputs are derived from registered state only.

## Structure
- Shared package/header csdf_pkg holds:
  - a clog2 constant function;
  - derivation of TAG_WIDTH and DATA_W from FLUX and WIDTH, shared with the accumulator so that tag packing matches.
- Sub-module csdf_tag_fifo provides one DATA_W × DEPTH synchronous FIFO with wr, rd, full, empty and head data.
- The top level instantiates csdf_tag_fifo FLUX times with a generate loop. It contains the tag decode, the full OR-reduce and the tag_err register.

## Test plan
All scenarios use FLUX=2, WIDTH=8, DEPTH=4 unless noted.
- Reset: assert rst for 1 cycle. Expect out_empty=2'b11, in0_full=0, tag_err=0.
- Routing: write 0x85 then 0x03. Expect:
  - out_data[13:7]=0x05 and out_empty[1]=0 one cycle after the first write;
  - out_data[6:0]=0x03 and out_empty[0]=0 one cycle after the second write.
- Backpressure and wrap: write 4 tokens with tag 0 (0x01–0x04). Expect in0_full=1 on the next cycle. Then:
  - a 5th write of 0x05 is dropped and tag_err=1;
  - pop once and write 0x06;
  - successive pops return 0x02, 0x03, 0x04, 0x06.
- Simultaneous read and write: hold FIFO 1 at count 2 while writing 0x90 and popping flux 1 in the same cycle. Expect the count to stay 2, order to be preserved, and in0_full=0.
- Bad tag: with FLUX=3, WIDTH=8, write tag 3 (0xC7). Expect tag_err=1 and every out_empty bit unchanged.
- Reset mid-stream: with FIFO 0 holding 3 entries, assert rst together with in0_wr=1. Expect all FIFOs empty and nothing stored.
